tcp_tx_sched: RTL and testbench
===============================

TCP_TX_SCHED -- requirements
Module: tcp_tx_sched

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, giving the maximum words sent per grant (legal range 1..255).
REQ-002 The block SHALL have parameter TAG_BASE, default 8'hA0, giving the tag byte base (source ID is ORed into bit 0).
REQ-003 BUS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 BUS_RST  in  1  reset; synchronous, active-high.
REQ-005 ENABLE  in  1  high allows new grants and fetches.
REQ-006 REQ_EMPTY  in  2  per-source FIFO empty; bit i is source i.
REQ-007 REQ_DATA  in  64  {source1[31:0], source0[31:0]}; first-word-fall-through, valid whenever the matching REQ_EMPTY bit is low.
REQ-008 REQ_READ  out  2  one-cycle pop strobe per source; combinational from state and grant.
REQ-009 TCP_TX_AFULL  in  1  downstream almost-full; tolerates 2 extra writes after assertion.
REQ-010 TCP_TX_WR  out  1  registered byte write strobe.
REQ-011 TCP_TX_DATA  out  8  registered byte; valid when TCP_TX_WR is high.
REQ-012 BUSY  out  1  high in any state other than IDLE.
REQ-013 WORD_CNT  out  16  total words fully sent since reset; wraps from 0xFFFF to 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FETCH and SEND.
REQ-015 IDLE: when ENABLE=1 and any REQ_EMPTY bit is low, the block SHALL register grant g and move to FETCH; otherwise it stays in IDLE.
REQ-016 Grant selection SHALL be round-robin: the source other than last_grant wins if it is requesting, otherwise last_grant wins; last_grant updates whenever a grant is made.
REQ-017 FETCH SHALL last one cycle: REQ_READ[g]=1, REQ_DATA word g latched into a 32-bit shift register, byte index set to 0, burst count incremented, then move to SEND.
REQ-018 REQ_READ[g] SHALL never assert while REQ_EMPTY[g]=1, and at most one REQ_READ bit SHALL be high in any cycle.
REQ-019 SEND: in each cycle with TCP_TX_AFULL=0, the next cycle SHALL show TCP_TX_WR=1 with byte k, and k SHALL advance; with TCP_TX_AFULL=1, the next cycle SHALL show TCP_TX_WR=0 and k SHALL hold.
REQ-020 The byte order per word SHALL be: k=0 is TAG_BASE|g; k=1..4 are word[31:24], [23:16], [15:8], [7:0].
REQ-021 After byte 4 is issued, WORD_CNT SHALL increment by 1.
REQ-022 After byte 4: if burst count < MAX_BURST, ENABLE=1 and REQ_EMPTY[g]=0, the FSM SHALL go to FETCH with the same g; otherwise it SHALL go to IDLE and clear the burst count.
REQ-023 ENABLE deasserting mid-word SHALL NOT abort the word: all 5 bytes complete, then IDLE.
REQ-024 Latency: a request seen in IDLE at cycle 0 gives REQ_READ at cycle 1 and the tag byte on TCP_TX_WR at cycle 3, assuming AFULL is low.
REQ-025 With AFULL low throughout, one word SHALL take 6 cycles (FETCH + 5 bytes), and back-to-back words within a burst SHALL have no extra idle cycle.
REQ-026 TCP_TX_DATA SHALL hold its last value while TCP_TX_WR=0.
REQ-027 REQ_EMPTY changes during SEND SHALL NOT affect the word in flight.

Reset
REQ-028 On BUS_RST=1 at a clock edge, the state SHALL become IDLE, burst count and byte index 0, and last_grant=1 so that source 0 wins the first tie.
REQ-029 Output reset values SHALL be: TCP_TX_WR=0, TCP_TX_DATA=8'h00, REQ_READ=2'b00, BUSY=0, WORD_CNT=0.
REQ-030 Reset mid-word SHALL discard the partial word, with no further bytes and no WORD_CNT increment; a word already popped from its FIFO is lost.

Verification
REQ-031 Source 0 holds one word 0x11223344, AFULL=0 -> bytes A0,11,22,33,44 on cycles 3..7, REQ_READ=01 on cycle 1, WORD_CNT=1, then IDLE.
REQ-032 Both sources hold 3 words each, MAX_BURST=2 -> source order 0,0,1,1,0,1, tags match each source, WORD_CNT=6.
REQ-033 AFULL=1 for 4 cycles during byte 2 -> TCP_TX_WR=0 on those 4 follow-on cycles, byte 2 repeats nothing and is skipped nowhere, and the stream stays A0,B3..B0 intact.
REQ-034 Source 1 holds 20 words, source 0 empty, default MAX_BURST -> 16-word burst, IDLE for 1 cycle, re-grant to source 1, 4 more words, WORD_CNT=20.
REQ-035 BUS_RST=1 after byte 2 of a word -> TCP_TX_WR=0 from the next cycle, WORD_CNT unchanged, BUSY=0.
REQ-036 ENABLE=0 after byte 1 with words still pending -> word completes, no further REQ_READ, BUSY=0.

Source files
------------

// File: rtl/tcp_tx_sched_if.sv
// Bundle between the TX scheduler, its two request FIFOs and the TCP byte sink.
interface tcp_tx_sched_if;
  logic [1:0]  REQ_EMPTY;
  logic [63:0] REQ_DATA;
  logic [1:0]  REQ_READ;
  logic        TCP_TX_AFULL;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;

  modport master (
    input  REQ_EMPTY, REQ_DATA, TCP_TX_AFULL,
    output REQ_READ, TCP_TX_WR, TCP_TX_DATA
  );

  modport slave (
    output REQ_EMPTY, REQ_DATA, TCP_TX_AFULL,
    input  REQ_READ, TCP_TX_WR, TCP_TX_DATA
  );
endinterface

// File: rtl/tcp_tx_sched.sv
// Round-robin scheduler draining two 32-bit request FIFOs into a tagged byte stream:
// each word goes out as one tag byte followed by its four bytes, MSB first.
module tcp_tx_sched #(
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] TAG_BASE  = 8'hA0
) (
  input  logic           BUS_CLK,
  input  logic           BUS_RST,
  input  logic           ENABLE,
  tcp_tx_sched_if.master bus,
  output logic           BUSY,
  output logic [15:0]    WORD_CNT
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2} state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [2:0] LAST_BYTE = 3'd4;

  state_t      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        grant_d;
  logic [7:0]  burst_cnt_q;
  logic [2:0]  byte_idx_q;
  logic [31:0] word_q;
  logic        wr_q;
  logic [7:0]  data_q;
  logic        busy_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  read_d;
  logic [31:0] fetch_word;
  logic        issue;

  assign fetch_word = grant_q ? bus.REQ_DATA[63:32] : bus.REQ_DATA[31:0];
  assign issue      = (state_q == SEND) && !bus.TCP_TX_AFULL;

  // The source that did not win last time has priority when both request.
  always_comb begin
    grant_d = last_grant_q;
    if (!bus.REQ_EMPTY[~last_grant_q]) grant_d = ~last_grant_q;
  end

  always_comb begin
    read_d = 2'b00;
    if (state_q == FETCH && !bus.REQ_EMPTY[grant_q]) read_d[grant_q] = 1'b1;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      byte_idx_q   <= 3'd0;
      wr_q         <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
      word_cnt_q   <= 16'd0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ENABLE && !(&bus.REQ_EMPTY)) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= FETCH;
            busy_q       <= 1'b1;
          end
        end
        FETCH: begin
          byte_idx_q  <= 3'd0;
          burst_cnt_q <= burst_cnt_q + 8'd1;
          state_q     <= SEND;
        end
        SEND: begin
          if (issue) begin
            wr_q       <= 1'b1;
            byte_idx_q <= byte_idx_q + 3'd1;
            data_q     <= (byte_idx_q == 3'd0) ? (TAG_BASE | {7'd0, grant_q}) : word_q[31:24];
            // ENABLE only gates the next fetch; a word already started always completes.
            if (byte_idx_q == LAST_BYTE) begin
              word_cnt_q <= word_cnt_q + 16'd1;
              if (burst_cnt_q < BURST_MAX && ENABLE && !bus.REQ_EMPTY[grant_q]) begin
                state_q <= FETCH;
              end else begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                burst_cnt_q <= 8'd0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word shift register: loaded on fetch, shifted after each payload byte.
  always_ff @(posedge BUS_CLK) begin
    if (state_q == FETCH) begin
      word_q <= fetch_word;
    end else if (issue && byte_idx_q != 3'd0) begin
      word_q <= {word_q[23:0], 8'h00};
    end
  end

  assign bus.REQ_READ    = read_d;
  assign bus.TCP_TX_WR   = wr_q;
  assign bus.TCP_TX_DATA = data_q;
  assign BUSY            = busy_q;
  assign WORD_CNT        = word_cnt_q;
endmodule

// File: tb/tb_tcp_tx_sched.sv
// Bench for tcp_tx_sched: default-burst and MAX_BURST=2 instances fed from modelled FIFOs,
// byte streams compared against a transaction-level round-robin reference.
module tb_tcp_tx_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        afull_man  = 1'b0;
  logic        afull_rand = 1'b0;
  logic        afull_r    = 1'b0;
  logic        flush      = 1'b1;
  logic        busy_a, busy_b;
  logic [15:0] wc_a_o, wc_b_o;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad   = 0;

  tcp_tx_sched_if ifa();
  tcp_tx_sched_if ifb();

  tcp_tx_sched dut_a (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en), .bus(ifa.master),
    .BUSY(busy_a), .WORD_CNT(wc_a_o)
  );

  tcp_tx_sched #(.MAX_BURST(2)) dut_b (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en), .bus(ifb.master),
    .BUSY(busy_b), .WORD_CNT(wc_b_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Request FIFO models, one pair per instance, loaded identically
  logic [31:0] mem  [2][2][256];
  logic [15:0] head [2][2];
  logic [15:0] tail [2][2];
  logic [1:0]  rd   [2];
  logic [1:0]  emp  [2];

  assign rd[0]  = ifa.REQ_READ;
  assign rd[1]  = ifb.REQ_READ;
  assign emp[0] = ifa.REQ_EMPTY;
  assign emp[1] = ifb.REQ_EMPTY;

  assign ifa.REQ_EMPTY    = {head[0][1] == tail[0][1], head[0][0] == tail[0][0]};
  assign ifb.REQ_EMPTY    = {head[1][1] == tail[1][1], head[1][0] == tail[1][0]};
  assign ifa.REQ_DATA     = {mem[0][1][head[0][1][7:0]], mem[0][0][head[0][0][7:0]]};
  assign ifb.REQ_DATA     = {mem[1][1][head[1][1][7:0]], mem[1][0][head[1][0][7:0]]};
  assign ifa.TCP_TX_AFULL = afull_rand ? afull_r : afull_man;
  assign ifb.TCP_TX_AFULL = afull_rand ? afull_r : afull_man;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (flush) head[i][s] <= tail[i][s];
        else if (rd[i][s]) head[i][s] <= head[i][s] + 16'd1;
      end
    end
  end

  always @(negedge clk) afull_r <= ($urandom_range(0, 2) == 0);

  // Output monitor: byte log with cycle stamps, pop counts, illegal-pop counts
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  b;
  } ev_t;
  ev_t blog_a[$];
  ev_t blog_b[$];
  int  rcnt [2] = '{0, 0};
  int  viol [2] = '{0, 0};

  always @(negedge clk) begin
    if (ifa.TCP_TX_WR === 1'b1) blog_a.push_back({cyc, ifa.TCP_TX_DATA});
    if (ifb.TCP_TX_WR === 1'b1) blog_b.push_back({cyc, ifb.TCP_TX_DATA});
    for (int i = 0; i < 2; i++) begin
      if (rd[i] == 2'b11 || (rd[i] & emp[i]) != 2'b00) viol[i] <= viol[i] + 1;
      if (rd[i] != 2'b00) rcnt[i] <= rcnt[i] + 1;
    end
  end

  // Reference model state
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];
  int          m_last [2];
  int          wc     [2];
  int          ptr    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] w);
    for (int i = 0; i < 2; i++) begin
      mem[i][s][tail[i][s][7:0]] = w;
      tail[i][s] = tail[i][s] + 16'd1;
    end
    if (s == 0) wq0.push_back(w);
    else wq1.push_back(w);
  endtask

  task automatic next_byte(input int inst, output logic [7:0] b);
    b = 8'hxx;
    if (inst == 0) begin
      if (ptr[0] < blog_a.size()) b = blog_a[ptr[0]].b;
      ptr[0]++;
    end else begin
      if (ptr[1] < blog_b.size()) b = blog_b[ptr[1]].b;
      ptr[1]++;
    end
  endtask

  // Replays round-robin arbitration over the words loaded since the last check.
  task automatic check_stream(input int inst, input int mb, input string tag);
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  e [5];
    int          g;
    int          n;
    int          left;
    q0 = wq0;
    q1 = wq1;
    while (q0.size() + q1.size() > 0) begin
      g = 1 - m_last[inst];
      if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) g = m_last[inst];
      m_last[inst] = g;
      n = 0;
      while (n < mb && ((g == 0 && q0.size() > 0) || (g == 1 && q1.size() > 0))) begin
        if (g == 0) w = q0.pop_front();
        else w = q1.pop_front();
        e[0] = 8'hA0 | 8'(g);
        e[1] = w[31:24];
        e[2] = w[23:16];
        e[3] = w[15:8];
        e[4] = w[7:0];
        for (int k = 0; k < 5; k++) begin
          next_byte(inst, b);
          chk($sformatf("%s i%0d w%0d b%0d", tag, inst, wc[inst], k), {24'd0, b}, {24'd0, e[k]});
        end
        wc[inst]++;
        n++;
      end
    end
    left = (inst == 0) ? blog_a.size() - ptr[0] : blog_b.size() - ptr[1];
    chk($sformatf("%s i%0d extra bytes", tag, inst), left, 0);
    chk($sformatf("%s i%0d word_cnt", tag, inst), (inst == 0) ? wc_a_o : wc_b_o, 16'(wc[inst]));
  endtask

  task automatic clear_model();
    wq0.delete();
    wq1.delete();
  endtask

  task automatic wait_done(input int limit, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && busy_b === 1'b0 && ifa.REQ_EMPTY === 2'b11 && ifb.REQ_EMPTY === 2'b11)
        done = 1'b1;
    end
    chk($sformatf("%s completes", tag), {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    m_last = '{1, 1};
    wc     = '{0, 0};
    ptr[0] = blog_a.size();
    ptr[1] = blog_b.size();
    clear_model();
  endtask

  initial begin
    logic [7:0]  exp1 [5];
    logic [31:0] w;
    logic [31:0] tmp[$];
    int          c0, p0, r0, r1, n0, n1;

    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 2; s++) tail[i][s] = 16'd0;
    m_last = '{1, 1};
    wc     = '{0, 0};
    ptr    = '{0, 0};
    repeat (3) @(negedge clk);

    chk("reset wr", {31'd0, ifa.TCP_TX_WR}, 32'd0);
    chk("reset data", {24'd0, ifa.TCP_TX_DATA}, 32'd0);
    chk("reset read", {30'd0, ifa.REQ_READ}, 32'd0);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset word_cnt", {16'd0, wc_a_o}, 32'd0);
    chk("reset b wr", {31'd0, ifb.TCP_TX_WR}, 32'd0);
    rst   = 1'b0;
    flush = 1'b0;
    en    = 1'b1;
    @(negedge clk);

    // Single word from source 0, exact cycle timing
    push(0, 32'h11223344);
    exp1 = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    chk("t1 read cyc1", {30'd0, ifa.REQ_READ}, 32'd1);
    @(negedge clk);
    chk("t1 wr cyc2", {31'd0, ifa.TCP_TX_WR}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1 wr cyc%0d", k + 3), {31'd0, ifa.TCP_TX_WR}, 32'd1);
      chk($sformatf("t1 data cyc%0d", k + 3), {24'd0, ifa.TCP_TX_DATA}, {24'd0, exp1[k]});
    end
    wait_done(20, "t1");
    chk("t1 busy", {31'd0, busy_a}, 32'd0);
    check_stream(0, 16, "t1");
    check_stream(1, 2, "t1");
    clear_model();

    // Three words per source from reset: burst-limited alternation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, $urandom());
      push(1, $urandom());
    end
    wait_done(200, "t2");
    check_stream(0, 16, "t2");
    check_stream(1, 2, "t2");
    clear_model();

    // Four-cycle AFULL stall right where byte 2 would issue
    push(0, 32'hB3B2B1B0);
    repeat (3) @(negedge clk);
    chk("t3 tag", {24'd0, ifa.TCP_TX_DATA}, 32'hA0);
    @(negedge clk);
    chk("t3 byte1", {24'd0, ifa.TCP_TX_DATA}, 32'hB3);
    afull_man = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("t3 stall wr %0d", j), {31'd0, ifa.TCP_TX_WR}, 32'd0);
      chk($sformatf("t3 stall hold %0d", j), {24'd0, ifa.TCP_TX_DATA}, 32'hB3);
    end
    afull_man = 1'b0;
    exp1 = '{8'hB2, 8'hB1, 8'hB0, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t3 resume wr %0d", k), {31'd0, ifa.TCP_TX_WR}, 32'd1);
      chk($sformatf("t3 resume data %0d", k), {24'd0, ifa.TCP_TX_DATA}, {24'd0, exp1[k]});
    end
    wait_done(20, "t3");
    check_stream(0, 16, "t3");
    check_stream(1, 2, "t3");
    clear_model();

    // 20 words on source 1 only: full burst, one idle cycle, re-grant
    p0 = ptr[0];
    for (int k = 0; k < 20; k++) push(1, $urandom());
    wait_done(400, "t4");
    chk("t4 back-to-back spacing",
        (blog_a.size() >= p0 + 100) ? blog_a[p0 + 5].cyc - blog_a[p0].cyc : 32'hxxxxxxxx, 32'd6);
    chk("t4 burst gap spacing",
        (blog_a.size() >= p0 + 100) ? blog_a[p0 + 80].cyc - blog_a[p0 + 75].cyc : 32'hxxxxxxxx, 32'd7);
    check_stream(0, 16, "t4");
    check_stream(1, 2, "t4");
    clear_model();

    // Reset after byte 2 of a word
    push(0, 32'hCAFEF00D);
    repeat (5) @(negedge clk);
    chk("t5 byte2", {24'd0, ifa.TCP_TX_DATA}, 32'hFE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 wr", {31'd0, ifa.TCP_TX_WR}, 32'd0);
    chk("t5 busy", {31'd0, busy_a}, 32'd0);
    chk("t5 word_cnt", {16'd0, wc_a_o}, 32'd0);
    ptr[0] = blog_a.size();
    ptr[1] = blog_b.size();
    m_last = '{1, 1};
    wc     = '{0, 0};
    clear_model();
    repeat (3) @(negedge clk);
    chk("t5 no more bytes a", blog_a.size() - ptr[0], 0);
    chk("t5 no more bytes b", blog_b.size() - ptr[1], 0);
    chk("t5 word lost", {16'd0, tail[0][0] - head[0][0]}, 32'd0);

    // ENABLE dropped after byte 1 with words still queued
    r0 = rcnt[0];
    r1 = rcnt[1];
    for (int k = 0; k < 3; k++) push(0, $urandom());
    w = wq0[0];
    repeat (4) @(negedge clk);
    chk("t6 byte1", {24'd0, ifa.TCP_TX_DATA}, {24'd0, w[31:24]});
    en = 1'b0;
    repeat (16) @(negedge clk);
    chk("t6 busy a", {31'd0, busy_a}, 32'd0);
    chk("t6 busy b", {31'd0, busy_b}, 32'd0);
    chk("t6 pops a", rcnt[0] - r0, 1);
    chk("t6 pops b", rcnt[1] - r1, 1);
    chk("t6 pending", {16'd0, tail[0][0] - head[0][0]}, 32'd2);
    tmp = wq0;
    wq0.delete();
    wq0.push_back(tmp[0]);
    check_stream(0, 16, "t6a");
    check_stream(1, 2, "t6a");
    wq0 = tmp[1:$];
    en = 1'b1;
    wait_done(100, "t6b");
    check_stream(0, 16, "t6b");
    check_stream(1, 2, "t6b");
    clear_model();

    // Random loads under random backpressure
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      afull_rand = 1'b1;
      for (int k = 0; k < n0; k++) push(0, $urandom());
      for (int k = 0; k < n1; k++) push(1, $urandom());
      wait_done(1000, $sformatf("rand%0d", r));
      afull_rand = 1'b0;
      check_stream(0, 16, $sformatf("rand%0d", r));
      check_stream(1, 2, $sformatf("rand%0d", r));
      clear_model();
    end

    chk("pop legality a", viol[0], 0);
    chk("pop legality b", viol[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
